ecc_dec_correct: RTL and testbench

// - Correction stage directly downstream of the 8-bit extended-Hamming syndrome stage.
// - Consumes the noisy codeword and its 4-bit syndrome column, then classifies the word:
//   no error, single error (corrected), or double error (detected only).
// - Registers the corrected word and data nibble behind a valid/ready handshake.
// - Keeps saturating counters of corrected and uncorrectable words.

---
 rtl/ecc_dec_correct.sv | 125 ++++++++++++
 tb/tb_ecc_dec_correct.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_dec_correct.sv
// Extended-Hamming (8,4) correction stage: classifies and corrects a codeword using its
// syndrome column, registers the result behind a valid/ready handshake, and keeps error statistics.
module ecc_dec_correct #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] NoisyCodeWord,
   input  logic [3:0]            column,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] corr_word,
   output logic [3:0]            data_out,
   output logic [1:0]            num_of_errors,
   input  logic                  cnt_clr,
   output logic [CNT_WIDTH-1:0]  cnt_corr,
   output logic [CNT_WIDTH-1:0]  cnt_uncorr
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic                  xfer;
   logic [7:0]            flip_mask;
   logic [1:0]            nerr_d;
   logic [DATA_WIDTH-1:0] corr_d;

   // in_ready is combinational so the stage can stream one word per cycle
   assign in_ready  = (state_q == EMPTY) || out_ready;
   assign xfer      = in_valid && in_ready;
   assign out_valid = (state_q == FULL);

   // Syndrome decode: locate the erroneous bit (single error) or flag a double error
   always_comb begin
      flip_mask = 8'h00;
      nerr_d    = 2'd0;
      if (column == 4'b0000) begin
         nerr_d = 2'd0;
      end else if (column[3]) begin
         nerr_d = 2'd1;
         case (column[2:0])
            3'b000:  flip_mask = 8'h08;
            3'b111:  flip_mask = 8'h80;
            3'b110:  flip_mask = 8'h40;
            3'b101:  flip_mask = 8'h20;
            3'b011:  flip_mask = 8'h10;
            3'b100:  flip_mask = 8'h04;
            3'b010:  flip_mask = 8'h02;
            3'b001:  flip_mask = 8'h01;
            default: flip_mask = 8'h00;
         endcase
      end else begin
         nerr_d = 2'd2;
      end
   end

   // Upper bits pass through untouched since the mask is zero-extended
   assign corr_d = NoisyCodeWord ^ DATA_WIDTH'(flip_mask);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (xfer) begin
               state_d = FULL;
            end
         end
         FULL: begin
            if (xfer) begin
               state_d = FULL;
            end else if (out_ready) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Result registers load only on a transfer; otherwise they hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         corr_word     <= '0;
         data_out      <= 4'h0;
         num_of_errors <= 2'd0;
      end else if (xfer) begin
         corr_word     <= corr_d;
         data_out      <= corr_d[7:4];
         num_of_errors <= nerr_d;
      end
   end

   // Saturating statistics; clear wins over a same-cycle increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_corr   <= '0;
         cnt_uncorr <= '0;
      end else if (cnt_clr) begin
         cnt_corr   <= '0;
         cnt_uncorr <= '0;
      end else if (xfer) begin
         if ((nerr_d == 2'd1) && !(&cnt_corr)) begin
            cnt_corr <= cnt_corr + CNT_WIDTH'(1);
         end
         if ((nerr_d == 2'd2) && !(&cnt_uncorr)) begin
            cnt_uncorr <= cnt_uncorr + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_ecc_dec_correct.sv
// Bench for ecc_dec_correct: directed vector table, handshake/saturation/reset sequences, and a
// randomized stream of encoded words with injected errors compared against a behavioural model.
module tb_ecc_dec_correct;

   localparam int unsigned DW = 32;
   // H columns for bits 7..0 (bit 3 is the overall-parity position, column 000)
   localparam logic [23:0] HCOLS = {3'b111, 3'b110, 3'b101, 3'b011,
                                    3'b000, 3'b100, 3'b010, 3'b001};

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          out_ready;
   logic          cnt_clr;
   logic [DW-1:0] noisy;
   logic [3:0]    column;

   logic          in_ready, out_valid;
   logic [DW-1:0] corr_word;
   logic [3:0]    data_out;
   logic [1:0]    nerr;
   logic [15:0]   cnt_corr, cnt_uncorr;

   logic          d2_in_ready, d2_out_valid;
   logic [DW-1:0] d2_corr_word;
   logic [3:0]    d2_data_out;
   logic [1:0]    d2_nerr;
   logic [1:0]    d2_cnt_corr, d2_cnt_uncorr;

   ecc_dec_correct #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .NoisyCodeWord(noisy), .column(column), .out_valid(out_valid), .out_ready(out_ready),
      .corr_word(corr_word), .data_out(data_out), .num_of_errors(nerr),
      .cnt_clr(cnt_clr), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr));

   ecc_dec_correct #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready),
      .NoisyCodeWord(noisy), .column(column), .out_valid(d2_out_valid), .out_ready(out_ready),
      .corr_word(d2_corr_word), .data_out(d2_data_out), .num_of_errors(d2_nerr),
      .cnt_clr(cnt_clr), .cnt_corr(d2_cnt_corr), .cnt_uncorr(d2_cnt_uncorr));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic          mv;
   logic [DW-1:0] mword;
   logic [1:0]    mnerr;
   int            mcorr, muncorr, mcorr2, muncorr2;

   typedef struct {
      logic [DW-1:0] w;
      logic [3:0]    c;
      logic [DW-1:0] ew;
      logic [1:0]    en;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] hcol(input int i);
      return HCOLS[3*i +: 3];
   endfunction

   // Behavioural decode: find the bit whose H column matches the syndrome
   function automatic void classify(input logic [DW-1:0] w, input logic [3:0] c,
                                    output logic [DW-1:0] ew, output logic [1:0] en);
      ew = w;
      en = 2'd0;
      if (c == 4'h0) begin
         en = 2'd0;
      end else if (c[3]) begin
         en = 2'd1;
         for (int i = 0; i < 8; i++) if (hcol(i) == c[2:0]) ew[i] = ~ew[i];
      end else begin
         en = 2'd2;
      end
   endfunction

   function automatic logic [7:0] encode(input logic [3:0] d);
      logic [7:0] cw;
      logic [2:0] ck;
      ck = 3'b000;
      for (int i = 0; i < 4; i++) if (d[i]) ck ^= hcol(i + 4);
      cw = {d, 1'b0, ck};
      cw[3] = ^cw;
      return cw;
   endfunction

   function automatic logic [3:0] syndrome(input logic [7:0] r);
      logic [2:0] s;
      s = 3'b000;
      for (int i = 0; i < 8; i++) if (r[i]) s ^= hcol(i);
      return {^r, s};
   endfunction

   function automatic int sat_inc(input int v, input int lim);
      return (v >= lim) ? lim : v + 1;
   endfunction

   task automatic model_reset();
      mv = 1'b0; mword = '0; mnerr = 2'd0;
      mcorr = 0; muncorr = 0; mcorr2 = 0; muncorr2 = 0;
   endtask

   task automatic check_outputs();
      chk("out_valid", 64'(out_valid), 64'(mv));
      chk("corr_word", 64'(corr_word), 64'(mword));
      chk("data_out", 64'(data_out), 64'(mword[7:4]));
      chk("num_of_errors", 64'(nerr), 64'(mnerr));
      chk("cnt_corr", 64'(cnt_corr), 64'(mcorr));
      chk("cnt_uncorr", 64'(cnt_uncorr), 64'(muncorr));
      chk("d2_cnt_corr", 64'(d2_cnt_corr), 64'(mcorr2));
      chk("d2_cnt_uncorr", 64'(d2_cnt_uncorr), 64'(muncorr2));
   endtask

   // One cycle: drive at negedge, check in_ready, advance model, check outputs at next negedge
   task automatic drive(input logic iv, input logic [DW-1:0] w, input logic [3:0] c,
                        input logic ordy, input logic clr);
      logic          xf;
      logic [DW-1:0] ew;
      logic [1:0]    en;
      in_valid = iv; noisy = w; column = c; out_ready = ordy; cnt_clr = clr;
      #1;
      chk("in_ready", 64'(in_ready), 64'(!mv || ordy));
      chk("d2_in_ready", 64'(d2_in_ready), 64'(!mv || ordy));
      xf = iv && (!mv || ordy);
      classify(w, c, ew, en);
      if (clr) begin
         mcorr = 0; muncorr = 0; mcorr2 = 0; muncorr2 = 0;
      end else if (xf) begin
         if (en == 2'd1) begin
            mcorr = sat_inc(mcorr, 65535); mcorr2 = sat_inc(mcorr2, 3);
         end
         if (en == 2'd2) begin
            muncorr = sat_inc(muncorr, 65535); muncorr2 = sat_inc(muncorr2, 3);
         end
      end
      if (xf) begin
         mv = 1'b1; mword = ew; mnerr = en;
      end else if (ordy) begin
         mv = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      logic [DW-1:0] held;
      logic [7:0]    cw, rx;
      logic [DW-1:0] w;
      int            n, bi, bj;

      tbl[0] = '{w: 32'h0000_00B1, c: 4'h0, ew: 32'h0000_00B1, en: 2'd0};
      tbl[1] = '{w: 32'h0000_00F1, c: 4'hE, ew: 32'h0000_00B1, en: 2'd1};
      tbl[2] = '{w: 32'h0000_00B9, c: 4'h8, ew: 32'h0000_00B1, en: 2'd1};
      tbl[3] = '{w: 32'h0000_00F0, c: 4'h7, ew: 32'h0000_00F0, en: 2'd2};
      tbl[4] = '{w: 32'hDEAD_BEF1, c: 4'hE, ew: 32'hDEAD_BEB1, en: 2'd1};
      tbl[5] = '{w: 32'hA5A5_0000, c: 4'h9, ew: 32'hA5A5_0001, en: 2'd1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
      noisy = '0; column = 4'h0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs();
      rst = 1'b0;

      // Directed vectors, each accepted into an empty or draining stage
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, tbl[k].w, tbl[k].c, 1'b1, 1'b0);
         chk("tbl_corr_word", 64'(corr_word), 64'(tbl[k].ew));
         chk("tbl_nerr", 64'(nerr), 64'(tbl[k].en));
         if (k == 1) chk("tbl_cnt_corr_first", 64'(cnt_corr), 64'd1);
         if (k == 3) chk("tbl_cnt_uncorr_first", 64'(cnt_uncorr), 64'd1);
      end
      drive(1'b0, '0, 4'h0, 1'b1, 1'b0);
      chk("drained_out_valid", 64'(out_valid), 64'd0);

      // Backpressure: held result stays stable while out_ready is low
      drive(1'b1, 32'h0000_00B1, 4'h0, 1'b0, 1'b0);
      held = corr_word;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h0000_00F1, 4'hE, 1'b0, 1'b0);
         chk("bp_held_word", 64'(corr_word), 64'(held));
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      drive(1'b1, 32'h0000_00F1, 4'hE, 1'b1, 1'b0);
      chk("bp_release_nerr", 64'(nerr), 64'd1);
      drive(1'b1, 32'h0000_00F0, 4'h7, 1'b1, 1'b0);
      drive(1'b1, 32'h0000_00B9, 4'h8, 1'b1, 1'b0);
      drive(1'b1, 32'h0000_00B1, 4'h0, 1'b1, 1'b0);
      chk("stream_out_valid", 64'(out_valid), 64'd1);

      // Saturation on the 2-bit instance, then clear racing an error
      drive(1'b0, '0, 4'h0, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) drive(1'b1, 32'h0000_00F1, 4'hE, 1'b1, 1'b0);
      chk("sat_d2_cnt_corr", 64'(d2_cnt_corr), 64'd3);
      chk("sat_cnt_corr", 64'(cnt_corr), 64'd5);
      drive(1'b1, 32'h0000_00F1, 4'hE, 1'b1, 1'b1);
      chk("clr_d2_cnt_corr", 64'(d2_cnt_corr), 64'd0);
      chk("clr_cnt_corr", 64'(cnt_corr), 64'd0);

      // Asynchronous reset while a result is held
      drive(1'b1, 32'h0000_00F1, 4'hE, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk("rst_async_out_valid", 64'(out_valid), 64'd0);
      chk("rst_async_d2_out_valid", 64'(d2_out_valid), 64'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
      rst = 1'b0;

      // Random stream of encoded words with 0, 1 or 2 injected errors
      for (int k = 0; k < 400; k++) begin
         cw = encode(4'($urandom_range(0, 15)));
         n  = int'($urandom_range(0, 2));
         rx = cw;
         bi = int'($urandom_range(0, 7));
         bj = (bi + int'($urandom_range(1, 7))) % 8;
         if (n >= 1) rx[bi] = ~rx[bi];
         if (n == 2) rx[bj] = ~rx[bj];
         w = {24'($urandom), rx};
         drive($urandom_range(0, 3) != 0, w, syndrome(rx),
               $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
         if (out_valid && (mnerr != 2'd2)) chk("rnd_corrected_low", 64'(corr_word[7:0]), 64'(encode(corr_word[7:4])));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
